// File: rtl/ram_ctrl_pkg.sv
// Shared types for the SRAM initiator: FSM state encodings and
// the strobe counter width.
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/ram_ctrl.sv
// Sequences one read/write request through SETUP, STROBE and HOLD on an
// async chip-select SRAM; all mem_* pins and rsp_* outputs are registered.
// Ports: clk, rst (async high); req_valid/ready/we/addr/wdata in;
// rsp_valid/we/rdata out; mem_addr/wdata/cs/we/oe out, mem_rdata in.
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int STROBE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_we,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe
);

  generate
    if (STROBE_CYCLES < 1 || STROBE_CYCLES > (2**CNT_W) - 1) begin : g_bad_strobe
      $error("ram_ctrl: STROBE_CYCLES out of range");
    end
  endgenerate

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STROBE_CYCLES - 1);

  state_t                state, nxt_state;
  logic [CNT_W-1:0]      cnt, nxt_cnt;
  logic                  op_we, nxt_op_we;
  logic                  nxt_cs, nxt_mwe, nxt_moe;
  logic                  nxt_rv, nxt_rwe;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic [DATA_WIDTH-1:0] nxt_wdata, nxt_rdata;

  assign req_ready = (state == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_op_we = op_we;
    nxt_addr  = mem_addr;
    nxt_wdata = mem_wdata;
    nxt_rdata = rsp_rdata;
    nxt_cs    = mem_cs;
    nxt_mwe   = 1'b0;
    nxt_moe   = 1'b0;
    nxt_rv    = 1'b0;
    nxt_rwe   = rsp_we;
    unique case (state)
      ST_IDLE: begin
        if (req_valid) begin
          nxt_state = ST_SETUP;
          nxt_op_we = req_we;
          nxt_addr  = req_addr;
          nxt_cs    = 1'b1;
          if (req_we) nxt_wdata = req_wdata;
        end
      end
      ST_SETUP: begin
        nxt_state = ST_STROBE;
        nxt_cnt   = '0;
        nxt_mwe   = op_we;
        nxt_moe   = !op_we;
      end
      ST_STROBE: begin
        nxt_cnt = cnt + 1'b1;
        if (cnt == LAST) begin
          // Sample the bus while oe is still high.
          nxt_state = ST_HOLD;
          nxt_rv    = 1'b1;
          nxt_rwe   = op_we;
          if (!op_we) nxt_rdata = mem_rdata;
        end else begin
          nxt_mwe = op_we;
          nxt_moe = !op_we;
        end
      end
      ST_HOLD: begin
        nxt_state = ST_IDLE;
        nxt_cs    = 1'b0;
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      op_we     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_oe    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      cnt       <= nxt_cnt;
      op_we     <= nxt_op_we;
      mem_addr  <= nxt_addr;
      mem_wdata <= nxt_wdata;
      mem_cs    <= nxt_cs;
      mem_we    <= nxt_mwe;
      mem_oe    <= nxt_moe;
      rsp_valid <= nxt_rv;
      rsp_we    <= nxt_rwe;
      rsp_rdata <= nxt_rdata;
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: S=2 instance checked every cycle against a
// transaction-level model, plus an S=1 instance with directed checks.
module tb_ram_ctrl;

  localparam int S = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       req_valid = 1'b0, req_we = 1'b0;
  logic [7:0] req_addr = '0, req_wdata = '0;
  logic       req_ready, rsp_valid, rsp_we;
  logic [7:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic       mem_cs, mem_we, mem_oe;

  logic       b_req_valid = 1'b0, b_req_we = 1'b0;
  logic [7:0] b_req_addr = '0, b_req_wdata = '0;
  logic       b_req_ready, b_rsp_valid, b_rsp_we;
  logic [7:0] b_rsp_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic       b_mem_cs, b_mem_we, b_mem_oe;

  ram_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .STROBE_CYCLES(S)) u0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe)
  );

  ram_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .STROBE_CYCLES(1)) u1 (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_we(b_rsp_we), .rsp_rdata(b_rsp_rdata),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .mem_cs(b_mem_cs), .mem_we(b_mem_we), .mem_oe(b_mem_oe)
  );

  // Async SRAM models
  logic [7:0] ram_a [256];
  logic [7:0] ram_b [256];
  always @(posedge clk) if (mem_cs && mem_we) ram_a[mem_addr] <= mem_wdata;
  always @(posedge clk) if (b_mem_cs && b_mem_we) ram_b[b_mem_addr] <= b_mem_wdata;
  assign mem_rdata   = (mem_cs && mem_oe) ? ram_a[mem_addr] : 8'h00;
  assign b_mem_rdata = (b_mem_cs && b_mem_oe) ? ram_b[b_mem_addr] : 8'h00;

  int checks = 0;
  int errs   = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // Transaction model: cycle k of a transfer counts from the accept
  // cycle (k=0); SETUP k=1, strobes k=2..S+1, HOLD k=S+2, ready at S+3.
  int         cyc = 0;
  bit         busy = 0, acc = 0, take;
  int         t0 = 0, acc_cyc = 0, k;
  bit         twe;
  logic [7:0] taddr, twd, last_rd;
  logic [7:0] mram [256];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mram[i]  = 8'h00;
      ram_a[i] = 8'h00;
      ram_b[i] = 8'h00;
    end
    last_rd = 8'h00;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    = 0;
      acc     = 0;
      last_rd = 8'h00;
    end else begin
      take = !busy && req_valid;
      cyc++;
      acc = 0;
      if (busy) begin
        if (cyc - t0 == S + 2) begin
          if (twe) mram[taddr] = twd;
          else last_rd = mram[taddr];
        end
        if (cyc - t0 == S + 3) busy = 0;
      end
      if (take) begin
        busy    = 1;
        t0      = cyc - 1;
        twe     = req_we;
        taddr   = req_addr;
        twd     = req_wdata;
        acc     = 1;
        acc_cyc = cyc;
      end
    end
  end

  // Per-cycle comparison of u0 against the model
  logic [7:0] rq_data [$];
  bit         rq_we [$];
  always @(negedge clk) begin
    if (!rst) begin
      k = cyc - t0;
      chk("ready", 32'(req_ready), 32'(!busy));
      chk("mem_cs", 32'(mem_cs), 32'(busy && k >= 1 && k <= S + 2));
      chk("mem_we", 32'(mem_we), 32'(busy && twe && k >= 2 && k <= S + 1));
      chk("mem_oe", 32'(mem_oe), 32'(busy && !twe && k >= 2 && k <= S + 1));
      chk("rsp_valid", 32'(rsp_valid), 32'(busy && k == S + 2));
      chk("rsp_rdata", 32'(rsp_rdata), 32'(last_rd));
      chk("we_oe_excl", 32'(mem_we & mem_oe), 32'(0));
      if (busy && k >= 1 && k <= S + 2) begin
        chk("mem_addr", 32'(mem_addr), 32'(taddr));
        if (twe) chk("mem_wdata", 32'(mem_wdata), 32'(twd));
      end
      if (rsp_valid) begin
        chk("rsp_we", 32'(rsp_we), 32'(twe));
        rq_data.push_back(rsp_rdata);
        rq_we.push_back(rsp_we);
      end
    end
  end

  // S=1 instance: record accept and response cycles
  int         b_acc [$];
  int         b_rc [$];
  logic [7:0] b_rd [$];
  bit         b_rw [$];
  always @(negedge clk) begin
    if (!rst) begin
      if (b_req_valid && b_req_ready) b_acc.push_back(cyc);
      if (b_rsp_valid) begin
        b_rc.push_back(cyc);
        b_rd.push_back(b_rsp_rdata);
        b_rw.push_back(b_rsp_we);
      end
    end
  end

  task automatic issue(input bit we, input logic [7:0] a, input logic [7:0] d,
                       output int ac);
    int n;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 40);
    chk("accept_seen", 32'(acc), 32'(1));
    ac = acc_cyc;
  endtask

  task automatic wait_rsp(input int cnt);
    int n;
    n = 0;
    while (rq_data.size() < cnt && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_count", 32'(rq_data.size()), 32'(cnt));
  endtask

  int a0, a1, prev, n;

  initial begin
    #1;
    chk("rst_ready", 32'(req_ready), 32'(1));
    chk("rst_mem", 32'({mem_cs, mem_we, mem_oe, mem_addr, mem_wdata}), 32'(0));
    chk("rst_rsp", 32'({rsp_valid, rsp_we, rsp_rdata}), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("idle_rsp_valid", 32'(rsp_valid), 32'(0));
    end

    // Single write then read
    issue(1'b1, 8'h3C, 8'hA5, a0);
    req_valid = 1'b0;
    wait_rsp(1);
    chk("wr_rsp_we", 32'(rq_we[0]), 32'(1));
    issue(1'b0, 8'h3C, 8'h00, a1);
    req_valid = 1'b0;
    wait_rsp(2);
    chk("rd_rsp_we", 32'(rq_we[1]), 32'(0));
    chk("rd_data_3c", 32'(rq_data[1]), 32'h0000_00A5);

    // Back-to-back with req_valid held
    rq_data.delete();
    rq_we.delete();
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      issue(i < 4, 8'(i % 4), 8'((i % 4) + 16), a0);
      if (i > 0) chk("b2b_gap", 32'(a0 - prev), 32'(5));
      prev = a0;
    end
    req_valid = 1'b0;
    wait_rsp(8);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_wr_we", 32'(rq_we[i]), 32'(1));
      chk("b2b_rd_we", 32'(rq_we[i + 4]), 32'(0));
      chk("b2b_rd_data", 32'(rq_data[i + 4]), 32'(8'h10 + 8'(i)));
    end

    // Reset during the second strobe cycle of a write
    rq_data.delete();
    rq_we.delete();
    issue(1'b1, 8'h7F, 8'h55, a0);
    req_valid = 1'b0;
    n = 0;
    while (cyc < a0 + 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    #2;
    chk("pre_rst_we", 32'(mem_we), 32'(1));
    chk("pre_rst_cs", 32'(mem_cs), 32'(1));
    rst = 1'b1;
    #1;
    chk("async_we_drop", 32'(mem_we), 32'(0));
    chk("async_cs_drop", 32'(mem_cs), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge clk);
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'(1));
    chk("no_rsp_after_rst", 32'(rq_data.size()), 32'(0));

    // S=1 instance: write 0x01=0xFF then read back, valid held
    @(negedge clk);
    b_req_valid = 1'b1;
    b_req_we    = 1'b1;
    b_req_addr  = 8'h01;
    b_req_wdata = 8'hFF;
    n = 0;
    while (b_acc.size() < 1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    b_req_we    = 1'b0;
    b_req_wdata = 8'h00;
    n = 0;
    while ((b_acc.size() < 2 || b_rc.size() < 2) && n < 30) begin
      @(negedge clk);
      if (b_acc.size() >= 2) b_req_valid = 1'b0;
      n++;
    end
    b_req_valid = 1'b0;
    chk("s1_accepts", 32'(b_acc.size()), 32'(2));
    chk("s1_rsps", 32'(b_rc.size()), 32'(2));
    if (b_acc.size() >= 2 && b_rc.size() >= 2) begin
      chk("s1_gap", 32'(b_acc[1] - b_acc[0]), 32'(4));
      chk("s1_latency", 32'(b_rc[0] - b_acc[0]), 32'(3));
      chk("s1_wr_we", 32'(b_rw[0]), 32'(1));
      chk("s1_rd_we", 32'(b_rw[1]), 32'(0));
      chk("s1_rd_data", 32'(b_rd[1]), 32'h0000_00FF);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

  initial begin
    #200000;
    errs++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule

// File: doc/ram_ctrl.md
# ram_ctrl

Synchronous initiator for the team's asynchronous chip-select SRAM model (`cs`/`we`/`oe` pins, tri-state read bus). It accepts single read/write requests on a valid/ready port, sequences the RAM pins through setup, strobe and hold phases, and returns one response per request. It sits between any clocked requester and the RAM instance.

## Interface
- `ADDR_WIDTH`, 8: RAM address width.
- `DATA_WIDTH`, 8: RAM data width.
- `STROBE_CYCLES`, 2: clock cycles `we`/`oe` stay asserted; legal range is 1 to 15.

Ports:
- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: controller can accept a request.
- `req_we` input 1: 1 = write, 0 = read.
- `req_addr` input `ADDR_WIDTH`: request address.
- `req_wdata` input `DATA_WIDTH`: write data.
- `rsp_valid` output 1: one-cycle response pulse.
- `rsp_we` output 1: echoes `req_we` of the completed request.
- `rsp_rdata` output `DATA_WIDTH`: read data; valid when `rsp_valid && !rsp_we`.
- `mem_addr` output `ADDR_WIDTH`: RAM address.
- `mem_wdata` output `DATA_WIDTH`: RAM `data_in`.
- `mem_rdata` input `DATA_WIDTH`: RAM `data_out`.
- `mem_cs`, `mem_we`, `mem_oe` output 1 each: RAM controls.

## Operation
- States: IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, register `req_we`, `req_addr` and `req_wdata`, then go to SETUP.
- SETUP (1 cycle):
  - `mem_cs`=1 and `mem_addr` driven.
  - For writes, `mem_wdata` is also driven.
  - `mem_we`=`mem_oe`=0.
  - Next state is STROBE and the strobe counter loads 0.
- STROBE (`STROBE_CYCLES` cycles):
  - `mem_we`=1 for writes; `mem_oe`=1 for reads.
  - The counter increments each cycle.
  - On the last STROBE cycle, register `mem_rdata` into `rsp_rdata` (reads only).
  - Next state is HOLD.
- HOLD (1 cycle):
  - Strobes are 0.
  - `mem_cs`, `mem_addr` and `mem_wdata` stay unchanged.
  - `rsp_valid`=1 and `rsp_we` reflects the completed request.
  - Next state is IDLE.
- Invariants:
  - `mem_we` and `mem_oe` are never both 1.
  - Address and data never change while a strobe is high.
- Writes leave `rsp_rdata` unchanged.
- `req_*` inputs are ignored outside IDLE.
- Counter width is 4 bits. A `STROBE_CYCLES` value outside the legal range is an elaboration error.

## Timing
- Reset values:
  - State IDLE and `req_ready`=1.
  - `rsp_valid`, `rsp_we`, `rsp_rdata`, `mem_addr`, `mem_wdata`, `mem_cs`, `mem_we` and `mem_oe` are all 0.
- Handshake: a transfer happens at the edge where `req_valid && req_ready` holds.
- Latency: with the accept edge at cycle 0, SETUP is cycle 1, STROBE is cycles 2 to 1+S, and HOLD with `rsp_valid` is cycle 2+S.
- `req_ready` returns to 1 at cycle 3+S. The maximum rate is one transaction per S+3 cycles.
- All `mem_*` outputs are registered, so no combinational path exists from `req_*` to `mem_*`.
- `req_ready` decodes state only.
- Reset asserted mid-transaction:
  - Strobes and `mem_cs` drop immediately (asynchronously).
  - No `rsp_valid` is produced and the in-flight request is discarded.
- A request held on `req_valid` during HOLD is accepted in the following IDLE cycle, not earlier.

## Structure
- Shared package `ram_ctrl_pkg` holds:
  - the 2-bit state encodings `ST_IDLE`=0, `ST_SETUP`=1, `ST_STROBE`=2, `ST_HOLD`=3;
  - the strobe counter width constant (4).
- Single flat module with no sub-module.
- Top-level benches instantiate `ram_ctrl` alongside the existing RAM model, with `mem_rdata` wired to the RAM read bus.

## Test plan
- Reset, then idle 5 cycles: `req_ready`=1, all `mem_*`=0, and `rsp_valid` never rises.
- Write addr 0x3C with data 0xA5 (S=2): `mem_cs` is high on cycles 1 to 4, `mem_we` is high on cycles 2 to 3, `mem_oe` stays 0, and `rsp_valid`=1 with `rsp_we`=1 on cycle 4.
- Read back 0x3C: `mem_oe` is high on cycles 2 to 3, and on cycle 4 `rsp_valid`=1, `rsp_we`=0 and `rsp_rdata`=0xA5.
- Back-to-back, `req_valid` held high for writes to 0x00 to 0x03 (data = address+0x10) followed by reads of the same addresses:
  - one accept every 5 cycles;
  - reads return 0x10 to 0x13 in order;
  - `mem_addr` is stable whenever any strobe is high.
- Reset asserted on the second STROBE cycle of a write to 0x7F with data 0x55:
  - `mem_we` and `mem_cs` fall without waiting for a clock;
  - no response is produced;
  - `req_ready`=1 after release.
- Build with S=1, then write 0x01 with 0xFF and read it back: accepts occur every 4 cycles and `rsp_rdata`=0xFF.
